centroid_div_sched: RTL
=======================

# centroid_div_sched

Sequencer for the colour-tracking IP's position stage. On each end-of-frame it captures the accumulated x_sum, y_sum and pixel count from the tracking datapath. It time-shares one iterative restoring divider between the two centroid divisions, x_sum/count then y_sum/count. It presents the resulting (x_pos, y_pos) to the drag-and-stamp logic over a valid/ready handshake. A zero count flags the target as lost.

## Interface
- SUM_W, 28: width of x_sum/y_sum; 640×480×639 fits.
- CNT_W, 19: width of count; covers 307200 pixels.
- POS_W, 10: width of x_pos/y_pos outputs.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_done  in  1  one-cycle pulse; x_sum/y_sum/count valid this cycle.
- x_sum  in  SUM_W  sum of matching-pixel x coordinates.
- y_sum  in  SUM_W  sum of matching-pixel y coordinates.
- count  in  CNT_W  number of matching pixels.
- pos_ready  in  1  downstream accepts the position.
- busy  out  1  high in any state other than IDLE.
- pos_valid  out  1  x_pos/y_pos/lost valid, held until accepted.
- x_pos  out  POS_W  centroid x (quotient, truncated).
- y_pos  out  POS_W  centroid y (quotient, truncated).
- lost  out  1  count was zero; positions are the last good values.
- drop  out  1  one-cycle pulse: frame_done ignored because not IDLE.

## Operation
- States:
  - IDLE: waiting for frame_done.
  - DIV_X: dividing x_sum by count.
  - DIV_Y: dividing y_sum by count.
  - OUT: presenting the result.
- IDLE:
  - On frame_done, latch x_sum, y_sum and count into operand registers.
  - If count != 0: load dividend = latched x_sum, clear remainder and iteration counter, go to DIV_X.
  - If count == 0: set lost = 1, leave x_pos/y_pos unchanged, go to OUT.
- Divider: restoring algorithm, one quotient bit per cycle, MSB first.
  - Remainder register is CNT_W+1 bits.
  - Each cycle: shift dividend MSB into the remainder.
  - If remainder >= count: subtract count and set quotient bit to 1; else quotient bit is 0.
- DIV_X runs exactly SUM_W iterations. It then stores the quotient into the x result, reloads the dividend with latched y_sum, clears the remainder and counter, and goes to DIV_Y.
- DIV_Y runs SUM_W iterations, stores the y result, sets lost = 0, and goes to OUT.
- Saturation: a quotient exceeding 2^POS_W−1 is clamped to 2^POS_W−1. Only the low POS_W bits are otherwise kept.
- x_pos/y_pos are updated from the divider only at DIV_X/DIV_Y completion. They are stable throughout OUT.
- OUT: pos_valid = 1. When pos_valid && pos_ready, go to IDLE. pos_valid drops the next cycle.
- frame_done in any non-IDLE state (including OUT on the same cycle as acceptance) is ignored and pulses drop for one cycle. Latched operands are not disturbed.

## Timing
- Reset values:
  - State is IDLE.
  - busy, pos_valid, lost and drop are 0.
  - x_pos and y_pos are 0.
  - Operand, remainder and counter registers are 0.
- Reset mid-operation abandons the division and forces all of the above on the next edge. The result of the abandoned division is never presented.
- Latency for count != 0:
  - frame_done is sampled at edge 0.
  - DIV_X covers edges 1..SUM_W.
  - DIV_Y covers edges SUM_W+1..2·SUM_W.
  - pos_valid is high from edge 2·SUM_W+1; that is cycle 57 at default parameters.
- Latency for count == 0: pos_valid is high from edge 1.
- busy is high from edge 1 until the cycle after acceptance.
- Earliest new frame_done accepted: the cycle after the pos_valid && pos_ready cycle.
- Throughput: at most one frame per 2·SUM_W+2 cycles. Frames are 307200 pixel-cycles, so no drops occur in normal operation.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic division: x_sum=3200, y_sum=2400, count=10, pos_ready=1 → pos_valid at cycle 57 with x_pos=320, y_pos=240, lost=0. IDLE at cycle 58.
- Full frame, max values: count=307200, x_sum=196300800, y_sum=147148800 → x_pos=639, y_pos=479. Truncation check: x_sum=7, y_sum=5, count=2 → x_pos=3, y_pos=2.
- Lost target: good frame giving (100,50), then frame with count=0 → pos_valid at cycle 1 after frame_done, lost=1, x_pos=100, y_pos=50.
- Backpressure: pos_ready held 0 for 20 cycles after pos_valid → pos_valid and values stay constant. A frame_done pulsed during OUT produces drop=1 for one cycle and does not change the result. Acceptance returns the block to IDLE.
- Overrun during divide: frame_done at cycle 10 of DIV_X with different sums → drop pulse. The final output matches the first frame's operands.
- Reset mid-operation: reset asserted at cycle 30 (in DIV_Y) → next cycle busy=0, pos_valid=0, x_pos=y_pos=0. A subsequent frame (3200, 2400, 10) yields (320, 240) 57 cycles later.

Source files
------------

// File: rtl/centroid_div_sched.sv
// rtl/centroid_div_sched.sv - end-of-frame centroid sequencer sharing one restoring divider for x and y
module centroid_div_sched #(
    parameter int SUM_W = 28,
    parameter int CNT_W = 19,
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_done,
    input  logic [SUM_W-1:0] x_sum,
    input  logic [SUM_W-1:0] y_sum,
    input  logic [CNT_W-1:0] count,
    input  logic             pos_ready,
    output logic             busy,
    output logic             pos_valid,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             lost,
    output logic             drop
);

    localparam int IW = $clog2(SUM_W);
    localparam logic [IW-1:0] LAST_ITER = IW'(SUM_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        OUT
    } state_t;

    state_t state;

    // x_sum is latched straight into the dividend; y_sum waits in y_op for the second pass
    logic [SUM_W-1:0] y_op;
    logic [CNT_W-1:0] cnt_op;
    logic [SUM_W-1:0] dividend;
    logic [CNT_W:0]   rem;
    logic [IW-1:0]    iter;

    logic [CNT_W:0]   rem_shift;
    logic [CNT_W:0]   rem_next;
    logic             q_bit;
    logic [SUM_W-1:0] quot_next;
    logic [POS_W-1:0] pos_sat;

    // Quotient bits shift into the dividend LSB, so after SUM_W steps it holds the quotient
    always_comb begin
        rem_shift = {rem[CNT_W-1:0], dividend[SUM_W-1]};
        q_bit     = (rem_shift >= {1'b0, cnt_op});
        rem_next  = q_bit ? (rem_shift - {1'b0, cnt_op}) : rem_shift;
        quot_next = {dividend[SUM_W-2:0], q_bit};
        pos_sat   = (|quot_next[SUM_W-1:POS_W]) ? {POS_W{1'b1}} : quot_next[POS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pos_valid <= 1'b0;
            lost      <= 1'b0;
            drop      <= 1'b0;
            x_pos     <= '0;
            y_pos     <= '0;
            y_op      <= '0;
            cnt_op    <= '0;
            dividend  <= '0;
            rem       <= '0;
            iter      <= '0;
        end else begin
            drop <= frame_done && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        y_op     <= y_sum;
                        cnt_op   <= count;
                        dividend <= x_sum;
                        rem      <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        if (count == '0) begin
                            lost      <= 1'b1;
                            pos_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            state <= DIV_X;
                        end
                    end
                end
                DIV_X, DIV_Y: begin
                    rem      <= rem_next;
                    dividend <= quot_next;
                    iter     <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        rem  <= '0;
                        iter <= '0;
                        if (state == DIV_X) begin
                            x_pos    <= pos_sat;
                            dividend <= y_op;
                            state    <= DIV_Y;
                        end else begin
                            y_pos     <= pos_sat;
                            lost      <= 1'b0;
                            pos_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (pos_ready) begin
                        pos_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
